mtm_alu_deserializer: RTL

- Input stage of mtm_Alu. Receives the serial `sin` stream, one bit per clk, and reassembles one packet: 8 data frames followed by 1 command frame.
- Checks the packet's framing, frame count, CRC4 and opcode.
- Delivers either {A, B, OP} with a one-cycle valid pulse, or an error pulse with cause flags, to the ALU core.

---
 rtl/mtm_alu_pkg.sv | 63 ++++++
 rtl/mtm_alu_deserializer_if.sv | 18 +
 rtl/mtm_alu_frame_rx.sv | 97 +++++++++
 rtl/mtm_alu_deserializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm_Alu input stage.
//   - operation_t      : opcodes accepted by the ALU core
//   - ERR_*_BIT/ERR_*  : bit positions and masks inside err_flags
//   - FRAME_BITS, DATA_FRAMES, CRC_INIT : serial protocol constants
//   - op_legal()       : true for the four supported opcodes
//   - crc4_d68()       : CRC4 (x^4+x+1) over the 68-bit message {B, A, 1'b1, OP},
//                        first bit B[31]. The deserializer's bit-serial LFSR must
//                        produce the same value.
package mtm_alu_pkg;

    localparam int FRAME_BITS  = 11;
    localparam int DATA_FRAMES = 8;
    localparam logic [3:0] CRC_INIT = 4'h0;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    localparam logic [2:0] ERR_DATA = 3'(1 << ERR_DATA_BIT);
    localparam logic [2:0] ERR_CRC  = 3'(1 << ERR_CRC_BIT);
    localparam logic [2:0] ERR_OP   = 3'(1 << ERR_OP_BIT);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_BITS,
        RX_HUNT
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_DATA,
        CHECK,
        REPORT,
        DRAIN
    } pkt_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] crc4_d68(input logic [67:0] d, input logic [3:0] crc);
        logic [3:0] c;
        logic       fb;
        c = crc;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// Result bus from the deserializer to the ALU core.
//   a, b      : operands of the last good packet
//   op        : opcode of the last good packet
//   out_valid : one-cycle pulse, a/b/op carry a new good packet
//   err_valid : one-cycle pulse, a packet was rejected
//   err_flags : {ERR_DATA, ERR_CRC, ERR_OP}, meaningful with err_valid
// master = deserializer (drives), slave = consumer.
interface mtm_alu_deserializer_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        err_valid;
    logic [2:0]  err_flags;

    modport master (output a, b, op, out_valid, err_valid, err_flags);
    modport slave  (input  a, b, op, out_valid, err_valid, err_flags);
endinterface

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level frame receiver: start(0), ctl, d7..d0, stop(1), one bit per clk.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sin          : serial input, idle high
//   frame_valid  : pulse, a frame with a good stop bit was received
//   frame_ctl    : ctl bit of that frame
//   frame_data   : d7..d0 of that frame
//   frame_err    : pulse, stop bit sampled 0 (receiver then waits for sin=1)
//   bit_valid    : pulse per data bit, so the CRC can run bit-serially
//   bit_ctl      : ctl bit of the frame the data bit belongs to
//   bit_idx      : 0 for d7 ... 7 for d0
//   bit_data     : the data bit
//   hunting      : receiver is waiting for sin=1 after a framing error
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic       frame_valid,
    output logic       frame_ctl,
    output logic [7:0] frame_data,
    output logic       frame_err,
    output logic       bit_valid,
    output logic       bit_ctl,
    output logic [2:0] bit_idx,
    output logic       bit_data,
    output logic       hunting
);

    // Position of the stop bit counted from the ctl bit (ctl = 0).
    localparam logic [3:0] STOP_POS = 4'(FRAME_BITS - 2);

    rx_state_t  state_reg;
    logic [3:0] cnt_reg;
    logic       ctl_reg;
    logic [7:0] shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            ctl_reg     <= 1'b0;
            shift_reg   <= '0;
            frame_valid <= 1'b0;
            frame_ctl   <= 1'b0;
            frame_data  <= '0;
            frame_err   <= 1'b0;
            bit_valid   <= 1'b0;
            bit_ctl     <= 1'b0;
            bit_idx     <= '0;
            bit_data    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            bit_valid   <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (!sin) begin
                        state_reg <= RX_BITS;
                        cnt_reg   <= '0;
                    end
                end
                RX_BITS: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd0) begin
                        ctl_reg <= sin;
                    end else if (cnt_reg < STOP_POS) begin
                        shift_reg <= {shift_reg[6:0], sin};
                        bit_valid <= 1'b1;
                        bit_ctl   <= ctl_reg;
                        bit_idx   <= 3'(cnt_reg - 4'd1);
                        bit_data  <= sin;
                    end else if (sin) begin
                        // Good stop: back to IDLE so the very next sample may be a start bit.
                        frame_valid <= 1'b1;
                        frame_ctl   <= ctl_reg;
                        frame_data  <= shift_reg;
                        state_reg   <= RX_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state_reg <= RX_HUNT;
                    end
                end
                RX_HUNT: begin
                    if (sin) begin
                        state_reg <= RX_IDLE;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

    assign hunting = (state_reg == RX_HUNT);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Input stage of mtm_Alu: reassembles 8 data frames + 1 command frame from sin,
// checks frame count / framing, CRC4 and opcode, and reports either a good
// {A, B, OP} with out_valid or an error with err_valid/err_flags.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sin        : serial input, idle high
//   alu        : result bus (master side), see mtm_alu_deserializer_if
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sin,
    mtm_alu_deserializer_if.master        alu
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_FRAMES);
    localparam logic [3:0] HALF_CNT = 4'(DATA_FRAMES / 2);
    localparam logic [3:0] SAT_CNT  = 4'(DATA_FRAMES + 1);

    logic       frame_valid;
    logic       frame_ctl;
    logic [7:0] frame_data;
    logic       frame_err;
    logic       bit_valid;
    logic       bit_ctl;
    logic [2:0] bit_idx;
    logic       bit_data;
    logic       rx_hunting;

    mtm_alu_frame_rx u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .frame_valid (frame_valid),
        .frame_ctl   (frame_ctl),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .bit_valid   (bit_valid),
        .bit_ctl     (bit_ctl),
        .bit_idx     (bit_idx),
        .bit_data    (bit_data),
        .hunting     (rx_hunting)
    );

    pkt_state_t  state_reg;
    logic [3:0]  frame_cnt_reg;
    logic [3:0]  crc_reg;
    logic [31:0] a_sh_reg;
    logic [31:0] b_sh_reg;
    logic [2:0]  cmd_op_reg;
    logic [3:0]  cmd_crc_reg;
    logic        ferr_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [2:0]  op_reg;
    logic        out_valid_reg;
    logic        err_valid_reg;
    logic [2:0]  err_flags_reg;

    // CRC feed: every data-frame bit, then for the command frame a constant 1
    // in place of d7 followed by the OP bits d6..d4. The CRC field itself is
    // not fed, so after d4 the register holds the CRC of {B, A, 1'b1, OP}.
    logic       crc_feed;
    logic       crc_bit;
    logic       crc_fb;
    logic [3:0] crc_next;

    always_comb begin
        crc_feed = 1'b0;
        crc_bit  = bit_data;
        if (bit_valid && state_reg == WAIT_DATA) begin
            if (!bit_ctl) begin
                crc_feed = 1'b1;
            end else if (bit_idx == 3'd0) begin
                crc_feed = 1'b1;
                crc_bit  = 1'b1;
            end else if (bit_idx <= 3'd3) begin
                crc_feed = 1'b1;
            end
        end
    end

    assign crc_fb   = crc_reg[3] ^ crc_bit;
    assign crc_next = {crc_reg[2:1], crc_reg[0] ^ crc_fb, crc_fb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= WAIT_DATA;
            frame_cnt_reg <= '0;
            crc_reg       <= CRC_INIT;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            cmd_op_reg    <= '0;
            cmd_crc_reg   <= '0;
            ferr_reg      <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            out_valid_reg <= 1'b0;
            err_valid_reg <= 1'b0;
            err_flags_reg <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            err_valid_reg <= 1'b0;
            case (state_reg)
                WAIT_DATA: begin
                    if (crc_feed) begin
                        crc_reg <= crc_next;
                    end
                    if (frame_err) begin
                        ferr_reg  <= 1'b1;
                        state_reg <= CHECK;
                    end else if (frame_valid) begin
                        if (!frame_ctl) begin
                            // Bytes past the 8th are dropped; the saturated count flags them.
                            if (frame_cnt_reg < HALF_CNT) begin
                                b_sh_reg <= {b_sh_reg[23:0], frame_data};
                            end else if (frame_cnt_reg < FULL_CNT) begin
                                a_sh_reg <= {a_sh_reg[23:0], frame_data};
                            end
                            if (frame_cnt_reg != SAT_CNT) begin
                                frame_cnt_reg <= frame_cnt_reg + 4'd1;
                            end
                        end else begin
                            cmd_op_reg  <= frame_data[6:4];
                            cmd_crc_reg <= frame_data[3:0];
                            state_reg   <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (ferr_reg || frame_cnt_reg != FULL_CNT) begin
                        err_valid_reg <= 1'b1;
                        err_flags_reg <= ERR_DATA;
                    end else if (crc_reg != cmd_crc_reg) begin
                        err_valid_reg <= 1'b1;
                        err_flags_reg <= ERR_CRC;
                    end else if (!op_legal(cmd_op_reg)) begin
                        err_valid_reg <= 1'b1;
                        err_flags_reg <= ERR_OP;
                    end else begin
                        out_valid_reg <= 1'b1;
                        a_reg         <= a_sh_reg;
                        b_reg         <= b_sh_reg;
                        op_reg        <= cmd_op_reg;
                    end
                    state_reg <= REPORT;
                end
                REPORT: begin
                    frame_cnt_reg <= '0;
                    crc_reg       <= CRC_INIT;
                    ferr_reg      <= 1'b0;
                    state_reg     <= ferr_reg ? DRAIN : WAIT_DATA;
                end
                DRAIN: begin
                    // Wait until the receiver has seen sin=1 again after the bad stop bit.
                    if (!rx_hunting) begin
                        state_reg <= WAIT_DATA;
                    end
                end
                default: state_reg <= WAIT_DATA;
            endcase
        end
    end

    assign alu.a         = a_reg;
    assign alu.b         = b_reg;
    assign alu.op        = op_reg;
    assign alu.out_valid = out_valid_reg;
    assign alu.err_valid = err_valid_reg;
    assign alu.err_flags = err_flags_reg;

endmodule
